// File: rtl/ins_queue.sv
// ins_queue: instruction prefetch FIFO with an integrated instruction register.
//
// Fetched words are held in a DEPTH-entry circular buffer. When the
// controller strobes loadIR, the head word is popped and split into an opcode
// field (upper OP_W bits) and an immediate/register field (remaining low
// bits). These fields are held for decode.
//
// Parameters
//   INS_W  instruction word width (must exceed OP_W)
//   OP_W   opcode width, taken from word bits [INS_W-1:INS_W-OP_W]
//   DEPTH  FIFO entries, power of two, >= 2
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   ins_in     instruction word from fetch
//   ins_valid  ins_in is valid this cycle
//   ins_ready  queue can accept a word (== !full)
//   loadIR     pop the head word into the instruction register
//   flush      drop all queued words and clear the register
//   opcode     registered opcode field
//   imed_reg   registered immediate/register field
//   ir_valid   opcode/imed_reg hold a live instruction
//   load_err   one-cycle pulse: loadIR arrived while the queue was empty
//   count      queued words, not counting the register
//   empty      count == 0
//   full       count == DEPTH
//
// Handshake: a word transfers on a rising edge where ins_valid && ins_ready
// (and flush is low). ins_valid may be raised independent of ins_ready, and
// ins_ready depends only on registered state, never on ins_valid.

module ins_queue #(
  parameter int INS_W = 8,
  parameter int OP_W  = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [INS_W-1:0]             ins_in,
  input  logic                         ins_valid,
  output logic                         ins_ready,
  input  logic                         loadIR,
  input  logic                         flush,
  output logic [OP_W-1:0]              opcode,
  output logic [INS_W-OP_W-1:0]        imed_reg,
  output logic                         ir_valid,
  output logic                         load_err,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IMM_W = INS_W - OP_W;

  logic [INS_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OP_W-1:0]  opcode_q, opcode_d;
  logic [IMM_W-1:0] imed_q, imed_d;
  logic             ir_valid_q, ir_valid_d;
  logic             load_err_q, load_err_d;

  logic             empty_w, full_w;
  logic             push, pop;
  logic [INS_W-1:0] head;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign head    = mem_q[rd_ptr_q];

  // Flush wins over both transfer directions. A load into an empty queue is
  // never a pop, even when a word is being pushed the same cycle (no bypass).
  assign push = ins_valid && !full_w && !flush;
  assign pop  = loadIR && !empty_w && !flush;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    opcode_d   = opcode_q;
    imed_d     = imed_q;
    ir_valid_d = ir_valid_q;
    load_err_d = 1'b0;

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      opcode_d   = '0;
      imed_d     = '0;
      ir_valid_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        opcode_d   = head[INS_W-1:IMM_W];
        imed_d     = head[IMM_W-1:0];
        ir_valid_d = 1'b1;
      end else if (loadIR) begin
        // Empty-queue load: fields keep their old values but are no longer live.
        ir_valid_d = 1'b0;
        load_err_d = 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      opcode_q   <= '0;
      imed_q     <= '0;
      ir_valid_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      opcode_q   <= opcode_d;
      imed_q     <= imed_d;
      ir_valid_q <= ir_valid_d;
      load_err_q <= load_err_d;
    end
  end

  // Buffer storage carries no reset; only pointers and count define content.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= ins_in;
    end
  end

  assign ins_ready = !full_w;
  assign opcode    = opcode_q;
  assign imed_reg  = imed_q;
  assign ir_valid  = ir_valid_q;
  assign load_err  = load_err_q;
  assign count     = count_q;
  assign empty     = empty_w;
  assign full      = full_w;

endmodule

// File: tb/tb_ins_queue.sv
// Bench for ins_queue: a default-parameter instance (8/4/4) and a wide
// instance (16/6/8) share clock and reset. A queue-based model predicts every
// output, and directed literal checks pin the model at key points.

module tb_ins_queue;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 0: INS_W=8, OP_W=4, DEPTH=4 ----------------
  logic [7:0] d0;
  logic       v0 = 1'b0, l0 = 1'b0, f0 = 1'b0;
  logic       rdy0, irv0, lerr0, e0, fl0;
  logic [3:0] op0, im0;
  logic [2:0] c0;

  ins_queue #(.INS_W(8), .OP_W(4), .DEPTH(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .ins_in(d0), .ins_valid(v0), .ins_ready(rdy0),
    .loadIR(l0), .flush(f0), .opcode(op0), .imed_reg(im0), .ir_valid(irv0),
    .load_err(lerr0), .count(c0), .empty(e0), .full(fl0)
  );

  // ---------------- DUT 1: INS_W=16, OP_W=6, DEPTH=8 ----------------
  logic [15:0] d1;
  logic        v1 = 1'b0, l1 = 1'b0, f1 = 1'b0;
  logic        rdy1, irv1, lerr1, e1, fl1;
  logic [5:0]  op1;
  logic [9:0]  im1;
  logic [3:0]  c1;

  ins_queue #(.INS_W(16), .OP_W(6), .DEPTH(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .ins_in(d1), .ins_valid(v1), .ins_ready(rdy1),
    .loadIR(l1), .flush(f1), .opcode(op1), .imed_reg(im1), .ir_valid(irv1),
    .load_err(lerr1), .count(c1), .empty(e1), .full(fl1)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic [15:0] m_opc [2];
  logic [15:0] m_imm [2];
  logic        m_irv [2];
  logic        m_lerr[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int id);
    return (id == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // One clock edge of the queue's behaviour, stated in terms of its rules.
  task automatic model_step(input int id, input logic rst, input logic v, input logic [15:0] d,
                            input logic l, input logic f, input int depth, input int insw,
                            input int opw);
    int n;
    logic [15:0] w;
    if (!rst || f) begin
      if (id == 0) exp_q0.delete(); else exp_q1.delete();
      m_opc[id] = '0; m_imm[id] = '0; m_irv[id] = 1'b0; m_lerr[id] = 1'b0;
    end else begin
      n = qsize(id);
      m_lerr[id] = l && (n == 0);
      if (l && n == 0) m_irv[id] = 1'b0;
      if (l && n != 0) begin
        w = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        m_opc[id] = w >> (insw - opw);
        m_imm[id] = w & ((16'd1 << (insw - opw)) - 16'd1);
        m_irv[id] = 1'b1;
      end
      if (v && n < depth) begin
        if (id == 0) exp_q0.push_back(d); else exp_q1.push_back(d);
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, rst_n, v0, {8'h00, d0}, l0, f0, 4, 8, 4);
    model_step(1, rst_n, v1, d1, l1, f1, 8, 16, 6);
    #1;
    check("d0_count", c0, qsize(0));
    check("d0_empty", e0, qsize(0) == 0);
    check("d0_full", fl0, qsize(0) == 4);
    check("d0_ready", rdy0, qsize(0) != 4);
    check("d0_opcode", op0, m_opc[0]);
    check("d0_imed", im0, m_imm[0]);
    check("d0_ir_valid", irv0, m_irv[0]);
    check("d0_load_err", lerr0, m_lerr[0]);
    check("d1_count", c1, qsize(1));
    check("d1_empty", e1, qsize(1) == 0);
    check("d1_full", fl1, qsize(1) == 8);
    check("d1_ready", rdy1, qsize(1) != 8);
    check("d1_opcode", op1, m_opc[1]);
    check("d1_imed", im1, m_imm[1]);
    check("d1_ir_valid", irv1, m_irv[1]);
    check("d1_load_err", lerr1, m_lerr[1]);
  end

  // ---------------- driver tasks (called just after a falling edge) ----------------
  task automatic step0(input logic v, input logic [7:0] d, input logic l, input logic f);
    v0 = v; d0 = d; l0 = l; f0 = f;
    @(negedge clk);
    v0 = 1'b0; l0 = 1'b0; f0 = 1'b0;
  endtask

  task automatic step1(input logic v, input logic [15:0] d, input logic l, input logic f);
    v1 = v; d1 = d; l1 = l; f1 = f;
    @(negedge clk);
    v1 = 1'b0; l1 = 1'b0; f1 = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    d0 = '0;
    d1 = '0;
    @(negedge clk);
    check("rst_count", c0, 0);
    check("rst_empty", e0, 1);
    check("rst_ready", rdy0, 1);
    check("rst_full", fl0, 0);
    check("rst_ir_valid", irv0, 0);
    check("rst_opcode", op0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single push then load
    step0(1'b1, 8'hA5, 1'b0, 1'b0);
    step0(1'b0, 8'h00, 1'b1, 1'b0);
    check("a5_opcode", op0, 4'hA);
    check("a5_imed", im0, 4'h5);
    check("a5_ir_valid", irv0, 1);
    check("a5_count", c0, 0);

    // Fill, refused fifth push, ordered drain
    for (int i = 1; i <= 4; i++) step0(1'b1, 8'(i * 8'h11), 1'b0, 1'b0);
    check("fill_full", fl0, 1);
    check("fill_ready", rdy0, 0);
    check("fill_count", c0, 4);
    step0(1'b1, 8'h55, 1'b0, 1'b0);
    check("fifth_count", c0, 4);
    for (int i = 1; i <= 4; i++) begin
      step0(1'b0, 8'h00, 1'b1, 1'b0);
      check("drain_opcode", op0, i);
      check("drain_imed", im0, i);
    end
    check("drain_empty", e0, 1);

    // Streaming across pointer wrap
    for (int i = 1; i <= 3; i++) step0(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step0(1'b1, 8'(8'h70 + i), 1'b1, 1'b0);
    check("wrap_count", c0, 3);
    check("wrap_opcode", op0, 4'h7);
    check("wrap_imed", im0, 4'h2);
    for (int i = 0; i < 3; i++) step0(1'b0, 8'h00, 1'b1, 1'b0);
    check("wrap_last_imed", im0, 4'h5);

    // Load on empty queue
    step0(1'b1, 8'h7C, 1'b0, 1'b0);
    step0(1'b0, 8'h00, 1'b1, 1'b0);
    check("7c_opcode", op0, 4'h7);
    check("7c_imed", im0, 4'hC);
    step0(1'b0, 8'h00, 1'b1, 1'b0);
    check("empty_ld_opcode", op0, 4'h7);
    check("empty_ld_imed", im0, 4'hC);
    check("empty_ld_ir_valid", irv0, 0);
    check("empty_ld_err", lerr0, 1);
    step0(1'b0, 8'h00, 1'b0, 1'b0);
    check("err_pulse_end", lerr0, 0);
    step0(1'b1, 8'hB2, 1'b1, 1'b0);
    check("push_ld_err", lerr0, 1);
    check("push_ld_count", c0, 1);
    step0(1'b0, 8'h00, 1'b1, 1'b0);
    check("b2_opcode", op0, 4'hB);
    check("b2_imed", im0, 4'h2);

    // Flush with concurrent push and load
    for (int i = 1; i <= 4; i++) step0(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    step0(1'b0, 8'h00, 1'b1, 1'b0);
    check("pre_flush_count", c0, 3);
    check("pre_flush_irv", irv0, 1);
    step0(1'b1, 8'h99, 1'b1, 1'b1);
    check("flush_count", c0, 0);
    check("flush_irv", irv0, 0);
    check("flush_opcode", op0, 0);
    check("flush_imed", im0, 0);
    check("flush_err", lerr0, 0);
    step0(1'b0, 8'h00, 1'b1, 1'b0);
    check("flush_dropped_err", lerr0, 1);

    // Asynchronous reset mid-stream
    step0(1'b1, 8'hD1, 1'b0, 1'b0);
    step0(1'b1, 8'hD2, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async_count", c0, 0);
    check("async_empty", e0, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Wide configuration
    step1(1'b1, 16'hFC03, 1'b0, 1'b0);
    step1(1'b0, 16'h0000, 1'b1, 1'b0);
    check("w_opcode", op1, 6'h3F);
    check("w_imed", im1, 10'h003);
    for (int i = 0; i < 4; i++) step1(1'b1, 16'(16'h1000 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step1(1'b1, 16'(16'h2000 + i), 1'b1, 1'b0);
      check("w_stream_count", c1, 4);
    end
    for (int i = 0; i < 4; i++) step1(1'b0, 16'h0000, 1'b1, 1'b0);
    check("w_last_opcode", op1, 6'h08);
    check("w_last_imed", im1, 10'h013);
    check("w_drained", e1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ins_queue.md
# ins_queue

Parametrised instruction prefetch queue with an integrated instruction register. It is the successor to the single-stage instruction register. Fetched instruction words are buffered in a DEPTH-entry FIFO. On the controller's load strobe the head word is split into opcode and immediate/register fields and held for decode. It sits between instruction memory/fetch and the controller, and adds a valid/ready handshake, flush, occupancy status and reset.

## Interface
- INS_W, default 8: instruction word width; must be greater than OP_W.
- OP_W, default 4: opcode width, taken from word bits [INS_W-1 : INS_W-OP_W].
- DEPTH, default 4: FIFO entries; power of two, at least 2.
- clk  in  1: clock; all state updates on its rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- ins_in  in  INS_W: instruction word from fetch.
- ins_valid  in  1: ins_in is valid this cycle.
- ins_ready  out  1: queue can accept a word; equals !full.
- loadIR  in  1: pop the head word into the instruction register.
- flush  in  1: discard all queued words and invalidate the register (branch/redirect).
- opcode  out  OP_W: registered opcode field.
- imed_reg  out  INS_W-OP_W: registered immediate/register field, bits [INS_W-OP_W-1:0].
- ir_valid  out  1: opcode/imed_reg hold a live instruction.
- load_err  out  1: one-cycle pulse when loadIR arrives while the queue is empty.
- count  out  $clog2(DEPTH+1): number of queued words, excluding the register.
- empty  out  1: count == 0.
- full  out  1: count == DEPTH.

## Operation
- Storage is a circular buffer of DEPTH x INS_W with read and write pointers of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH.
- Push occurs when ins_valid && ins_ready. The word is written at the write pointer, which then increments.
- Pop occurs when loadIR && !empty:
  - opcode <= head[INS_W-1:INS_W-OP_W]
  - imed_reg <= head[INS_W-OP_W-1:0]
  - ir_valid <= 1
  - the read pointer increments.
- loadIR while empty:
  - opcode and imed_reg hold their values.
  - ir_valid <= 0.
  - load_err pulses high for exactly one cycle.
- With loadIR low, the register holds and ir_valid holds.
- A simultaneous push and pop (queue neither empty nor full) leaves count unchanged. Both pointers advance.
- Pushing into an empty queue and loading in the same cycle is not a pop: the queue is empty that cycle, so load_err fires. The pushed word is retained. There is no bypass path.
- When full, ins_ready = 0, so no push is accepted even if a pop happens in the same cycle. ins_ready rises the cycle after the pop.
- Priority: reset > flush > push/pop.
  - flush zeroes count and both pointers and forces ir_valid <= 0, opcode <= 0, imed_reg <= 0.
  - Any push or loadIR in the flush cycle is ignored, and load_err stays 0.
- Buffer contents are not reset; only pointers and count are.

## Timing
- Reset (rst_n low, takes effect asynchronously): opcode=0, imed_reg=0, ir_valid=0, load_err=0, count=0, empty=1, full=0, ins_ready=1, pointers=0.
- After rst_n is released, operation begins on the first rising edge.
- A word pushed at edge N is poppable by a loadIR sampled at edge N+1. Its fields appear on opcode/imed_reg after that edge.
- loadIR-to-field latency is 1 cycle: outputs update on the edge that samples loadIR.
- count, empty, full and ins_ready are registered or derived from registered count. They reflect all pushes and pops of the previous edge.
- Asserting rst_n low mid-stream discards all queued words immediately, without waiting for a clock edge.

## Test plan
- Reset, default parameters: hold rst_n low, then release -> all outputs at reset values, ins_ready=1, empty=1.
- Push 0xA5, then loadIR -> opcode=0xA, imed_reg=0x5, ir_valid=1, count returns to 0.
- Fill the queue:
  - Push 0x11, 0x22, 0x33, 0x44 -> full=1, ins_ready=0, count=4; a fifth push of 0x55 is refused.
  - Four loadIRs -> opcode/imed_reg sequence 1/1, 2/2, 3/3, 4/4 in order.
  - Push/pop across pointer wrap-around preserves order.
- loadIR on an empty queue after loading 0x7C:
  - opcode=0x7 and imed_reg=0xC hold, ir_valid=0, load_err high for exactly 1 cycle.
  - Same-cycle push + loadIR on an empty queue -> load_err=1, count=1.
- Flush with count=3 and ir_valid=1, with a concurrent push and loadIR -> count=0, ir_valid=0, opcode=0, imed_reg=0, load_err=0, the pushed word is dropped.
- INS_W=16, OP_W=6, DEPTH=8:
  - Push 0xFC03 -> opcode=0x3F, imed_reg=0x003.
  - Streaming simultaneous push/pop at steady count=4 for 20 cycles -> count constant, data order preserved.
